// File: rtl/alu_seq_param.sv
// Registered parametric ALU for the EX stage.
// Single-cycle logic ops plus an iterative shift-add unsigned multiply.
module alu_seq_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [3:0]            ALUOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Zero,
  output logic                  Overflow
);

  localparam int W = DATA_WIDTH;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_MULU = 4'h8;

  // W is a power of two, so the iteration count is a single set MSB
  localparam logic [SHAMT_WIDTH:0] CNT_INIT =
    {1'b1, {SHAMT_WIDTH{1'b0}}};
  localparam logic [SHAMT_WIDTH:0] CNT_ONE =
    {{SHAMT_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {IDLE, MUL} state_t;

  state_t                 state_q;
  logic [SHAMT_WIDTH:0]   cnt_q;
  logic [2*W-1:0]         mcand_q;
  logic [W-1:0]           mplier_q;
  logic [2*W-1:0]         acc_q;
  logic [2*W-1:0]         acc_d;

  logic [W-1:0]           sum;
  logic [W-1:0]           diff;
  logic [W-1:0]           alu_r;
  logic                   alu_v;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign sum   = A + B;
  assign diff  = A - B;
  assign shamt = B[SHAMT_WIDTH-1:0];

  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (ALUOperation)
      OP_AND: alu_r = A & B;
      OP_OR:  alu_r = A | B;
      OP_ADD: begin
        alu_r = sum;
        alu_v = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
      end
      OP_SUB: begin
        alu_r = diff;
        alu_v = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
      end
      OP_SLL: alu_r = A << shamt;
      OP_NOR: alu_r = ~(A | B);
      OP_SRL: alu_r = A >> shamt;
      OP_SLT: alu_r = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_r = '0;
    endcase
  end

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ALUResult <= '0;
      ResultHi  <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start && ALUOperation == OP_MULU) begin
            mcand_q  <= {{W{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= CNT_INIT;
            Busy     <= 1'b1;
            state_q  <= MUL;
          end else if (Start) begin
            ALUResult <= alu_r;
            ResultHi  <= '0;
            Zero      <= (alu_r == '0);
            Overflow  <= alu_v;
            Done      <= 1'b1;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            ALUResult <= acc_d[W-1:0];
            ResultHi  <= acc_d[2*W-1:W];
            Zero      <= (acc_d == '0);
            Overflow  <= 1'b0;
            Done      <= 1'b1;
            Busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at 32-bit and 8-bit widths.
// Vector table for single-cycle ops, hand sequences for multiply and reset.
module tb_alu_seq_param;

  logic        clk;
  logic        reset;

  logic        s32;
  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, z32, v32;
  logic [31:0] r32, hi32;

  logic        s8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, z8, v8;
  logic [7:0]  r8, hi8;

  int total = 0;
  int bad   = 0;

  alu_seq_param #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut32 (
    .clk(clk), .reset(reset), .Start(s32), .ALUOperation(op32),
    .A(a32), .B(b32), .Busy(busy32), .Done(done32),
    .ALUResult(r32), .ResultHi(hi32), .Zero(z32), .Overflow(v32)
  );

  alu_seq_param #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) dut8 (
    .clk(clk), .reset(reset), .Start(s8), .ALUOperation(op8),
    .A(a8), .B(b8), .Busy(busy8), .Done(done8),
    .ALUResult(r8), .ResultHi(hi8), .Zero(z8), .Overflow(v8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        v;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk); #1;
    s32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    s8 = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  task automatic chk_all0(input string nm);
    chk({nm, ".busy32"}, 64'(busy32), 64'd0);
    chk({nm, ".done32"}, 64'(done32), 64'd0);
    chk({nm, ".r32"},    64'(r32),    64'd0);
    chk({nm, ".hi32"},   64'(hi32),   64'd0);
    chk({nm, ".z32"},    64'(z32),    64'd0);
    chk({nm, ".v32"},    64'(v32),    64'd0);
    chk({nm, ".busy8"},  64'(busy8),  64'd0);
    chk({nm, ".r8"},     64'(r8),     64'd0);
  endtask

  int n;
  int nd;

  initial begin
    vt[0]  = '{4'h0, 32'hFFFF0000, 32'h0FF00FF0, 32'h0FF00000, 1'b0, 1'b0};
    vt[1]  = '{4'h1, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0};
    vt[2]  = '{4'h2, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0};
    vt[3]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{4'h3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vt[5]  = '{4'h3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    vt[6]  = '{4'h4, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0};
    vt[7]  = '{4'h5, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[8]  = '{4'h6, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0};
    vt[9]  = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vt[10] = '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vt[11] = '{4'hF, 32'h00000005, 32'h00000007, 32'h00000000, 1'b1, 1'b0};
    vt[12] = '{4'h4, 32'h00000ABC, 32'h00000020, 32'h00000ABC, 1'b0, 1'b0};
    vt[13] = '{4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};

    reset = 1'b0;
    s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    s8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all0("rst_init");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      issue32(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d.done", i), 64'(done32), 64'd1);
      chk($sformatf("vec%0d.r", i),    64'(r32),    64'(vt[i].r));
      chk($sformatf("vec%0d.hi", i),   64'(hi32),   64'd0);
      chk($sformatf("vec%0d.z", i),    64'(z32),    64'(vt[i].z));
      chk($sformatf("vec%0d.v", i),    64'(v32),    64'(vt[i].v));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.pulse", i), 64'(done32), 64'd0);
    end

    // asynchronous reset mid-cycle after a nonzero result
    issue32(4'h2, 32'd1, 32'd2);
    chk("pre_rst.r", 64'(r32), 64'd3);
    #2;
    reset = 1'b0;
    #1;
    chk_all0("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    issue32(4'h2, 32'd1, 32'd2);
    chk("post_rst.done", 64'(done32), 64'd1);
    chk("post_rst.r",    64'(r32),    64'd3);
    @(posedge clk); #1;
    chk("post_rst.pulse", 64'(done32), 64'd0);

    // 32-bit multiply with an ignored Start mid-flight
    issue32(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul.busy0", 64'(busy32), 64'd1);
    chk("mul.done0", 64'(done32), 64'd0);
    chk("mul.hold",  64'(r32),    64'd3);
    nd = 0;
    for (n = 1; n <= 100; n++) begin
      if (n == 5) begin
        s32 = 1'b1; op32 = 4'h0; a32 = '0; b32 = '0;
      end
      @(posedge clk); #1;
      s32 = 1'b0;
      if (done32) break;
      if (!busy32) nd++;
    end
    chk("mul.edges",  64'(n),      64'd32);
    chk("mul.busyok", 64'(nd),     64'd0);
    chk("mul.lo",     64'(r32),    64'h00000001);
    chk("mul.hi",     64'(hi32),   64'hFFFFFFFE);
    chk("mul.z",      64'(z32),    64'd0);
    chk("mul.busy1",  64'(busy32), 64'd0);
    @(posedge clk); #1;
    chk("mul.pulse",  64'(done32), 64'd0);
    chk("mul.keep",   64'(r32),    64'h00000001);

    // reset pulsed mid-multiply aborts it
    issue32(4'h8, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_all0("mul_abort");
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || busy32) nd++;
    end
    chk("abort.quiet", 64'(nd), 64'd0);

    issue32(4'h8, 32'd3, 32'd4);
    for (n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done32) break;
    end
    chk("mul34.edges", 64'(n),    64'd32);
    chk("mul34.lo",    64'(r32),  64'd12);
    chk("mul34.hi",    64'(hi32), 64'd0);
    issue32(4'h1, 32'd1, 32'd2);
    chk("b2b.done", 64'(done32), 64'd1);
    chk("b2b.r",    64'(r32),    64'd3);
    chk("b2b.hi",   64'(hi32),   64'd0);
    chk("b2b.busy", 64'(busy32), 64'd0);

    // 8-bit instance
    issue8(4'h8, 8'hFF, 8'h02);
    chk("w8mul.busy", 64'(busy8), 64'd1);
    for (n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done8) break;
    end
    chk("w8mul.edges", 64'(n),   64'd8);
    chk("w8mul.lo",    64'(r8),  64'hFE);
    chk("w8mul.hi",    64'(hi8), 64'h01);
    issue8(4'h2, 8'h80, 8'h80);
    chk("w8add.r", 64'(r8), 64'h00);
    chk("w8add.z", 64'(z8), 64'd1);
    chk("w8add.v", 64'(v8), 64'd1);
    chk("w8add.hi", 64'(hi8), 64'd0);
    issue8(4'h6, 8'h80, 8'h0F);
    chk("w8srl.r", 64'(r8), 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
